// File: rtl/guess_entry.sv
// Guess entry: debounces three push-buttons and builds a 4-digit BCD guess.
// Latency: press event DEB_CYCLES+2 cycles after a raw low; start/wr/err +1 cycle, check +2 cycles.
// Backpressure: none; pulses are single-cycle strobes and LOCKED silences all outputs until reset.
module guess_entry #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        btn_start_n,
   input  logic        btn_enter_n,
   input  logic        btn_check_n,
   input  logic [1:0]  choise,
   input  logic [3:0]  num,
   input  logic        lock,
   output logic [15:0] guess,
   output logic        start_pulse,
   output logic        wr_pulse,
   output logic        err_pulse,
   output logic        check_pulse,
   output logic [1:0]  state
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ARMED  = 2'b01,
      LOCKED = 2'b10
   } state_t;

   // Button index: 0 = start, 1 = enter, 2 = check.
   logic [2:0]    btn_raw;
   logic [2:0]    sync1_q, sync2_q;
   logic [2:0]    stable_q, stable_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   logic [2:0]    press_q, press_d;

   state_t        state_q, state_d;
   logic [15:0]   guess_q, guess_d;
   logic          start_q, start_d;
   logic          wr_q, wr_d;
   logic          err_q, err_d;
   logic          check_q, check_d;
   logic          chk_pend_q, chk_pend_d;

   assign btn_raw = {btn_check_n, btn_enter_n, btn_start_n};

   // Debounce: a level is accepted only after DEB_CYCLES consecutive disagreeing samples.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      // Only a released->pressed transition is an event; releases are dropped.
      press_d = stable_q & ~stable_d;
   end

   // Game FSM: start arms entry, lock freezes everything until reset.
   always_comb begin
      state_d    = state_q;
      guess_d    = guess_q;
      start_d    = 1'b0;
      wr_d       = 1'b0;
      err_d      = 1'b0;
      check_d    = 1'b0;
      chk_pend_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (press_q[0]) begin
               state_d = ARMED;
               start_d = 1'b1;
            end
         end
         ARMED: begin
            if (lock) begin
               // Game over wins over any press arriving in the same cycle.
               state_d = LOCKED;
            end else begin
               if (press_q[1]) begin
                  if (num <= 4'd9) begin
                     case (choise)
                        2'd0:    guess_d[3:0]   = num;
                        2'd1:    guess_d[7:4]   = num;
                        2'd2:    guess_d[11:8]  = num;
                        default: guess_d[15:12] = num;
                     endcase
                     wr_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               // Check is delayed one extra cycle so a same-cycle write is already in guess.
               chk_pend_d = press_q[2];
               check_d    = chk_pend_q;
            end
         end
         LOCKED: begin
            state_d = LOCKED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state, with synchronous active-low reset to the released/idle condition.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync1_q    <= 3'b111;
         sync2_q    <= 3'b111;
         stable_q   <= 3'b111;
         press_q    <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
         state_q    <= IDLE;
         guess_q    <= 16'h0000;
         start_q    <= 1'b0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         check_q    <= 1'b0;
         chk_pend_q <= 1'b0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         stable_q   <= stable_d;
         press_q    <= press_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         state_q    <= state_d;
         guess_q    <= guess_d;
         start_q    <= start_d;
         wr_q       <= wr_d;
         err_q      <= err_d;
         check_q    <= check_d;
         chk_pend_q <= chk_pend_d;
      end
   end

   assign guess       = guess_q;
   assign start_pulse = start_q;
   assign wr_pulse    = wr_q;
   assign err_pulse   = err_q;
   assign check_pulse = check_q;
   assign state       = state_q;

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 Parameter DEB_CYCLES, default 50000, number of consecutive stable cycles needed to accept a button level change.
REQ-002 CLK  input  1  system clock; every flop in the block is clocked on its rising edge.
REQ-003 RST_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-004 btn_start_n  input  1  raw start push-button, active-low, asynchronous to CLK.
REQ-005 btn_enter_n  input  1  raw digit-enter push-button, active-low, asynchronous to CLK.
REQ-006 btn_check_n  input  1  raw guess-check push-button, active-low, asynchronous to CLK.
REQ-007 choise  input  2  digit slot selector, 0 = rightmost digit, 3 = leftmost digit.
REQ-008 num  input  4  value to write into the selected slot, from DIP switches.
REQ-009 lock  input  1  level input from the game/timer stage; high means the game is over (won or timed out).
REQ-010 guess  output  16  BCD guess, {digit3,digit2,digit1,digit0}, registered.
REQ-011 start_pulse  output  1  one-cycle strobe marking game start.
REQ-012 wr_pulse  output  1  one-cycle strobe marking an accepted digit write.
REQ-013 err_pulse  output  1  one-cycle strobe marking a rejected write because num > 9.
REQ-014 check_pulse  output  1  one-cycle strobe requesting comparison of guess.
REQ-015 state  output  2  current FSM state: 00 IDLE, 01 ARMED, 10 LOCKED.

Function
REQ-016 Each raw button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-017 Debounce, per button:
- Keep a stable level and a counter.
- The counter SHALL clear whenever the synchronized level equals the stable level.
- Otherwise the counter SHALL increment.
- On reaching DEB_CYCLES-1, the stable level SHALL take the synchronized level and the counter SHALL clear.
REQ-018 Press event: one cycle, generated on a stable 1->0 transition only; releases SHALL generate nothing.
REQ-019 A raw low held continuously from cycle t SHALL produce its press event in cycle t+DEB_CYCLES+2.
- A glitch shorter than DEB_CYCLES cycles SHALL produce no event.
REQ-020 Holding a button low SHALL produce exactly one press event.
REQ-021 IDLE -> ARMED on a start press; start_pulse SHALL be high in the cycle after the press event.
- Enter and check presses in IDLE SHALL be ignored.
REQ-022 ARMED, enter press with num <= 9:
- digit[choise] <= num.
- wr_pulse high in the following cycle.
- The guess update is visible in that same following cycle.
REQ-023 ARMED, enter press with num > 9: all digits unchanged; err_pulse high in the following cycle.
REQ-024 ARMED, check press: check_pulse high 2 cycles after the press event, so that a write accepted in the same cycle is already in guess.
REQ-025 ARMED, lock sampled high: next state LOCKED.
- lock takes priority; an enter or check press in that same cycle SHALL be discarded.
REQ-026 LOCKED SHALL be absorbing until reset.
- In LOCKED: guess frozen, all pulse outputs held low, start presses ignored.
REQ-027 A start press in ARMED SHALL be ignored; digits are not cleared.
REQ-028 wr_pulse, err_pulse and check_pulse SHALL never be high for two consecutive cycles from a single button press.

Reset
REQ-029 While RST_N is low at a clock edge, the block SHALL force:
- state = IDLE;
- guess = 16'h0000;
- all pulse outputs = 0;
- debounce stable levels = 1 (released);
- debounce counters = 0;
- synchronizer flops = 1.
REQ-030 A reset mid-debounce or mid-game SHALL discard any pending press; no pulse SHALL appear in the cycle after RST_N rises.
REQ-031 A button held low across reset release SHALL produce one press event DEB_CYCLES+2 cycles after release.
- This follows because the stable level resets to released.

Verification (DEB_CYCLES=4)
REQ-032 Reset, then btn_start_n low for 10 cycles -> exactly one start_pulse; state = 01.
REQ-033 ARMED, choise=2, num=7, btn_enter_n low 10 cycles -> one wr_pulse; guess = 16'h0700.
REQ-034 ARMED, num=4'hC, enter press -> one err_pulse; guess unchanged; no wr_pulse.
REQ-035 btn_check_n low pulses of 3 cycles, then a clean press of 8 cycles -> exactly one check_pulse, from the clean press only.
REQ-036 Enter and check press events in the same cycle, choise=0, num=5 -> wr_pulse at +1, check_pulse at +2; guess[3:0] = 5 when check_pulse is high.
REQ-037 lock=1 in ARMED -> state = 10; later enter, check and start presses produce no pulses; RST_N low for one cycle -> state = 00, guess = 0.
